tx_port_channel_gate_sync: RTL and testbench



---
 rtl/tx_port_channel_gate_sync_pkg.sv | 18 +
 rtl/tx_port_channel_gate_sync_fifo.sv | 44 ++++
 rtl/tx_port_channel_gate_sync.sv | 121 ++++++++++++
 tb/tb_tx_port_channel_gate_sync.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tx_port_channel_gate_sync_pkg.sv
// tx_port_gate_pkg: gate FSM states, field widths and FIFO marker packing
// shared by the TX channel gate.
package tx_port_gate_pkg;
    localparam int LEN_W = 32;
    localparam int OFF_W = 31;
    localparam int CNT_W = 32;
    localparam int MRK_W = LEN_W + OFF_W + 1;

    typedef enum logic [1:0] {IDLE, OPENING, OPEN, CLOSE} gate_state_t;

    function automatic logic [MRK_W-1:0] pack_header(input logic [LEN_W-1:0] len, input logic [OFF_W-1:0] off, input logic last);
        return {len, off, last};
    endfunction

    function automatic logic [MRK_W-1:0] pack_close(input logic short_xfer, input logic [CNT_W-1:0] count);
        return MRK_W'({short_xfer, count});
    endfunction
endpackage

// File: rtl/tx_port_channel_gate_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO; full asserts one
// entry early so a write already registered upstream always fits.
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             do_rd;

    assign empty   = occupancy == '0;
    assign do_rd   = rd_en & ~empty;
    assign full    = occupancy >= (AW+1)'(DEPTH - 1);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            occupancy <= occupancy + (AW+1)'(wr_en) - (AW+1)'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/tx_port_channel_gate_sync.sv
// tx_port_channel_gate_sync: captures a TX channel transaction (header, data
// beats, close marker with word count and short flag) into a local FIFO.
module tx_port_channel_gate_sync
    import tx_port_gate_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 64,
    parameter int C_FIFO_DEPTH  = 16,
    parameter int C_ENFORCE_LEN = 0,
    localparam int C_FIFO_DATA_WIDTH = C_DATA_WIDTH + 1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    output logic [C_FIFO_DATA_WIDTH-1:0] RD_DATA,
    output logic                         RD_EMPTY,
    input  logic                         RD_EN,
    input  logic                         CHNL_TX,
    output logic                         CHNL_TX_ACK,
    input  logic                         CHNL_TX_LAST,
    input  logic [31:0]                  CHNL_TX_LEN,
    input  logic [30:0]                  CHNL_TX_OFF,
    input  logic [C_DATA_WIDTH-1:0]      CHNL_TX_DATA,
    input  logic                         CHNL_TX_DATA_VALID,
    output logic                         CHNL_TX_DATA_REN
);
    localparam int BEAT_WORDS = C_DATA_WIDTH / 32;

    gate_state_t                  state;
    gate_state_t                  nxt_state;
    logic                         r_tx;
    logic                         r_last;
    logic [LEN_W-1:0]             r_len;
    logic [OFF_W-1:0]             r_off;
    logic [LEN_W-1:0]             len_q;
    logic [CNT_W-1:0]             count;
    logic [CNT_W:0]               count_sum;
    logic                         full;
    logic                         limit;
    logic                         accept;
    logic                         hdr_wr;
    logic                         cls_wr;
    logic                         wr_en;
    logic [C_FIFO_DATA_WIDTH-1:0] wr_data;
    logic [C_FIFO_DATA_WIDTH-1:0] wr_nxt;
    logic [$clog2(C_FIFO_DEPTH):0] occupancy;

    assign RD_EMPTY  = occupancy == '0;
    assign limit     = C_ENFORCE_LEN != 0 && count >= len_q;
    assign accept    = CHNL_TX_DATA_REN & CHNL_TX_DATA_VALID;
    assign count_sum = {1'b0, count} + (CNT_W+1)'(BEAT_WORDS);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tx   <= 1'b0;
            r_last <= 1'b0;
            r_len  <= '0;
            r_off  <= '0;
        end else begin
            r_tx   <= CHNL_TX;
            r_last <= CHNL_TX_LAST;
            r_len  <= CHNL_TX_LEN;
            r_off  <= CHNL_TX_OFF;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    if (hdr_wr) nxt_state = OPENING;
            OPENING: nxt_state = r_tx ? OPEN : CLOSE;
            OPEN:    if (!r_tx) nxt_state = CLOSE;
            CLOSE:   if (!full) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        hdr_wr           = state == IDLE && r_tx && !full;
        cls_wr           = state == CLOSE && !full;
        CHNL_TX_DATA_REN = state == OPEN && CHNL_TX && r_tx && !full && !limit;
        wr_nxt           = hdr_wr ? {1'b1, C_DATA_WIDTH'(pack_header(r_len, r_off, r_last))} :
                           cls_wr ? {1'b1, C_DATA_WIDTH'(pack_close(count < len_q, count))} :
                                    {1'b0, CHNL_TX_DATA};
    end

    // Every FIFO write goes through one register stage, which is why full is early.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            CHNL_TX_ACK <= 1'b0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            len_q       <= '0;
            count       <= '0;
        end else begin
            CHNL_TX_ACK <= hdr_wr;
            wr_en       <= hdr_wr | cls_wr | accept;
            wr_data     <= wr_nxt;
            if (hdr_wr) len_q <= r_len;
            count <= state == IDLE ? '0 :
                     accept ? (count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0]) : count;
        end
    end

    sync_fifo #(
        .WIDTH (C_FIFO_DATA_WIDTH),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (RD_EN),
        .rd_data   (RD_DATA),
        .occupancy (occupancy),
        .full      (full)
    );
endmodule

// File: tb/tb_tx_port_channel_gate_sync.sv
// tb_tx_port_channel_gate_sync: directed and randomized transactions checked
// against a transaction-level scoreboard of expected FIFO entries.
module tb_tx_port_channel_gate_sync;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int BW    = DW / 32;
    localparam int FW    = DW + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_en = 1'b0;
    logic          chnl_tx = 1'b0;
    logic          chnl_last = 1'b0;
    logic          chnl_valid = 1'b0;
    logic [31:0]   chnl_len = '0;
    logic [30:0]   chnl_off = '0;
    logic [DW-1:0] chnl_data = '0;
    logic [FW-1:0] rd_data;
    logic          rd_empty;
    logic          ack;
    logic          ren;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] exp_q[$];

    always #5 clk = ~clk;

    tx_port_channel_gate_sync #(
        .C_DATA_WIDTH  (DW),
        .C_FIFO_DEPTH  (DEPTH),
        .C_ENFORCE_LEN (1)
    ) dut (
        .CLK                (clk),
        .RST_N              (rst_n),
        .RD_DATA            (rd_data),
        .RD_EMPTY           (rd_empty),
        .RD_EN              (rd_en),
        .CHNL_TX            (chnl_tx),
        .CHNL_TX_ACK        (ack),
        .CHNL_TX_LAST       (chnl_last),
        .CHNL_TX_LEN        (chnl_len),
        .CHNL_TX_OFF        (chnl_off),
        .CHNL_TX_DATA       (chnl_data),
        .CHNL_TX_DATA_VALID (chnl_valid),
        .CHNL_TX_DATA_REN   (ren)
    );

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic sample_pop();
        if (rd_en && !rd_empty) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL extra_entry: observed %0h expected none", rd_data);
            end else chk("fifo_entry", rd_data, exp_q.pop_front());
        end
    endtask

    // One transaction: open, offer up to n_offer beats, drop CHNL_TX, drain.
    task automatic run_txn(input logic [31:0] len, input logic [30:0] off, input logic last,
                           input int n_offer, input int vpct, input int rpct, input int min_cyc,
                           input int rd_start, input int fill_chk);
        int acc = 0, it = 0, ack_cnt = 0, ack_it = -1, first_ren = -1, exp_acc, d;
        longint words_allowed;
        logic [31:0] cnt;
        words_allowed = (longint'(len) + BW - 1) / BW;
        exp_acc = words_allowed < n_offer ? int'(words_allowed) : n_offer;
        exp_q.push_back({1'b1, len, off, last});
        chnl_len = len;
        chnl_off = off;
        chnl_last = last;
        chnl_tx = 1'b1;
        while (it < 200 && (it < min_cyc || acc < n_offer)) begin
            chnl_valid = acc < n_offer && $urandom_range(99) < vpct;
            chnl_data = {$urandom, $urandom};
            rd_en = it >= rd_start && $urandom_range(99) < rpct;
            #1;
            if (ack) begin
                ack_cnt++;
                if (ack_it < 0) ack_it = it;
            end
            if (ren) begin
                if (first_ren < 0) first_ren = it;
                chk("ren_legal", FW'(it >= 3 && longint'(acc) * BW < longint'(len)), FW'(1));
                if (chnl_valid) begin
                    exp_q.push_back({1'b0, chnl_data});
                    acc++;
                end
            end
            if (it == fill_chk) begin
                chk("fill_accepted", FW'(acc), FW'(DEPTH - 1));
                chk("fill_ren_low", FW'(ren), FW'(0));
            end
            sample_pop();
            @(posedge clk); #2;
            it++;
        end
        chnl_tx = 1'b0;
        chnl_valid = 1'b0;
        cnt = 32'(acc * BW);
        exp_q.push_back({1'b1, 31'b0, cnt < len, cnt});
        for (d = 0; d < 200 && exp_q.size() > 0; d++) begin
            rd_en = $urandom_range(99) < 80;
            #1;
            if (ack) begin
                ack_cnt++;
                if (ack_it < 0) ack_it = it;
            end
            chk("ren_closed", FW'(ren), FW'(0));
            sample_pop();
            @(posedge clk); #2;
            it++;
        end
        rd_en = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("beats_accepted", FW'(acc), FW'(exp_acc));
        chk("ack_pulses", FW'(ack_cnt), FW'(1));
        chk("ack_cycle", FW'(ack_it), FW'(2));
        chk("queue_drained", FW'(exp_q.size()), FW'(0));
        chk("empty_after", FW'(rd_empty), FW'(1));
        if (exp_acc > 0) chk("first_ren_cycle", FW'(first_ren), FW'(3));
    endtask

    initial begin
        int n;
        #1;
        chk("rst_empty", FW'(rd_empty), FW'(1));
        chk("rst_ack", FW'(ack), FW'(0));
        chk("rst_ren", FW'(ren), FW'(0));
        chk("rst_data", rd_data, FW'(0));
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #2;

        run_txn(32'd8, 31'h1234_5678, 1'b1, 4, 100, 0, 0, 1000, -1);
        run_txn(32'd16, 31'h0000_0040, 1'b0, 2, 100, 50, 0, 0, -1);
        run_txn(32'd4, 31'h7, 1'b1, 100, 100, 0, 13, 1000, -1);
        run_txn(32'd6, 31'h0, 1'b0, 0, 100, 0, 1, 1000, -1);
        run_txn(32'd0, 31'h55, 1'b1, 5, 100, 0, 12, 1000, -1);
        run_txn(32'd40, 31'h3, 1'b0, 20, 100, 100, 0, 30, 29);

        // Reset in the middle of an open transaction.
        chnl_len = 32'd20;
        chnl_tx = 1'b1;
        chnl_valid = 1'b1;
        rd_en = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && n < 3; i++) begin
            chnl_data = {$urandom, $urandom};
            #1;
            if (ren) n++;
            @(posedge clk); #2;
        end
        chk("rst_mid_beats", FW'(n), FW'(3));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_empty", FW'(rd_empty), FW'(1));
        chk("rst_mid_ren", FW'(ren), FW'(0));
        chk("rst_mid_ack", FW'(ack), FW'(0));
        chk("rst_mid_data", rd_data, FW'(0));
        chnl_tx = 1'b0;
        chnl_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #2;
        run_txn(32'd8, 31'h99, 1'b1, 4, 100, 60, 0, 0, -1);

        for (int t = 0; t < 8; t++)
            run_txn(32'($urandom_range(24)), 31'($urandom), 1'($urandom), int'($urandom_range(14)),
                    int'($urandom_range(50, 100)), int'($urandom_range(30, 100)),
                    int'($urandom_range(1, 4)), 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
